// File: rtl/tcdm_burst_sequencer_if.sv
// Command / sub-burst request / response bus of the TCDM burst sequencer.
// Signal names carry the direction suffix as seen from the sequencer.
interface tcdm_burst_sequencer_if #(
   parameter int unsigned MaxBlen     = 4,
   parameter int unsigned LenWidth    = 8,
   parameter int unsigned AddrWidth   = 32,
   parameter int unsigned MetaIdWidth = 4
);
   localparam int unsigned BlenW = $clog2(MaxBlen) + 1;

   logic [AddrWidth-1:0]   cmd_addr_i;
   logic [LenWidth-1:0]    cmd_len_i;
   logic [MetaIdWidth-1:0] cmd_id_i;
   logic                   cmd_valid_i;
   logic                   cmd_ready_o;

   logic [AddrWidth-1:0]   breq_addr_o;
   logic [BlenW-1:0]       breq_blen_o;
   logic [MetaIdWidth-1:0] breq_id_o;
   logic                   breq_valid_o;
   logic                   breq_ready_i;

   logic                   rsp_valid_i;
   logic [BlenW-1:0]       rsp_words_i;

   // Sequencer side
   modport slave (
      input  cmd_addr_i, cmd_len_i, cmd_id_i, cmd_valid_i,
      output cmd_ready_o,
      output breq_addr_o, breq_blen_o, breq_id_o, breq_valid_o,
      input  breq_ready_i,
      input  rsp_valid_i, rsp_words_i
   );

   // Front-end / crossbar side
   modport master (
      output cmd_addr_i, cmd_len_i, cmd_id_i, cmd_valid_i,
      input  cmd_ready_o,
      input  breq_addr_o, breq_blen_o, breq_id_o, breq_valid_o,
      output breq_ready_i,
      output rsp_valid_i, rsp_words_i
   );
endinterface

// File: rtl/tcdm_burst_sequencer.sv
// TCDM burst sequencer: splits one word-granular transfer command into
// MaxBlen-group-aligned sub-bursts, limits words in flight by a credit
// count and pulses done_o once every issued word has returned.
module tcdm_burst_sequencer #(
   parameter int unsigned NrBanks        = 16,
   parameter int unsigned MaxBlen        = 4,
   parameter int unsigned LenWidth       = 8,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned ByteOffset     = 2,
   parameter int unsigned MetaIdWidth    = 4,
   parameter int unsigned MaxOutstanding = 8
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   tcdm_burst_sequencer_if.slave               bus,
   output logic                                busy_o,
   output logic                                done_o,
   output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o
);

   localparam int unsigned BlenW = $clog2(MaxBlen) + 1;
   localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
   localparam int unsigned SumW  = $clog2(2 * MaxOutstanding + 1);
   localparam int unsigned WidxW = AddrWidth - ByteOffset;

   if (MaxBlen > NrBanks) begin : g_err_blen
      $error("MaxBlen must not exceed NrBanks");
   end
   if ((NrBanks == 0) || ((NrBanks & (NrBanks - 1)) != 0)) begin : g_err_banks
      $error("NrBanks must be a power of 2");
   end
   if ((MaxBlen == 0) || ((MaxBlen & (MaxBlen - 1)) != 0)) begin : g_err_blen_pow2
      $error("MaxBlen must be a power of 2");
   end
   if (MaxOutstanding < MaxBlen) begin : g_err_out
      $error("MaxOutstanding must be at least MaxBlen");
   end

   typedef enum logic [1:0] {Idle, Issue, Drain} state_e;

   state_e                 state_q, state_d;
   logic [WidxW-1:0]       widx_q, widx_d;
   logic [LenWidth-1:0]    rem_q, rem_d;
   logic [MetaIdWidth-1:0] id_q, id_d;
   logic [OutW-1:0]        out_q, out_d;
   logic                   done_q, done_d;
   logic                   valid_q, valid_d;
   logic [AddrWidth-1:0]   addr_q;
   logic [BlenW-1:0]       blen_q, sub_d, room_d;
   logic [MetaIdWidth-1:0] bid_q;

   logic                   hs, rsp_en, underflow;
   logic [SumW-1:0]        sum, out_nx;
   logic [WidxW-1:0]       grp_off;

   // Next-state of the sequencer; the next sub-burst is derived from the
   // next-state pointers so the request can be registered without a
   // combinational path from the command port.
   always_comb begin
      hs        = valid_q & bus.breq_ready_i;
      sum       = SumW'(out_q) + (hs ? SumW'(blen_q) : '0);
      rsp_en    = bus.rsp_valid_i && (state_q != Idle);
      underflow = rsp_en && (SumW'(bus.rsp_words_i) > sum);
      out_nx    = sum;
      if (rsp_en) out_nx = underflow ? '0 : (sum - SumW'(bus.rsp_words_i));
      out_d     = OutW'(out_nx);

      state_d = state_q;
      widx_d  = widx_q;
      rem_d   = rem_q;
      id_d    = id_q;
      done_d  = 1'b0;
      case (state_q)
         Idle: begin
            if (bus.cmd_valid_i) begin
               widx_d = WidxW'(bus.cmd_addr_i >> ByteOffset);
               rem_d  = bus.cmd_len_i;
               id_d   = bus.cmd_id_i;
               if (bus.cmd_len_i != '0) state_d = Issue;
               else                     done_d  = 1'b1;
            end
         end
         Issue: begin
            if (hs) begin
               widx_d = widx_q + WidxW'(blen_q);
               id_d   = id_q + MetaIdWidth'(blen_q);
               rem_d  = rem_q - LenWidth'(blen_q);
               if (rem_d == '0) state_d = Drain;
            end
         end
         Drain: begin
            if (out_d == '0) begin
               state_d = Idle;
               done_d  = 1'b1;
            end
         end
         default: state_d = Idle;
      endcase

      grp_off = widx_d & WidxW'(MaxBlen - 1);
      room_d  = BlenW'(MaxBlen) - BlenW'(grp_off);
      sub_d   = (32'(rem_d) < 32'(room_d)) ? BlenW'(rem_d) : room_d;
      valid_d = (state_d == Issue) &&
                ((SumW'(out_d) + SumW'(sub_d)) <= SumW'(MaxOutstanding));
   end

   // State, pointers, credit counter and registered request outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Idle;
         widx_q  <= '0;
         rem_q   <= '0;
         id_q    <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         blen_q  <= '0;
         bid_q   <= '0;
      end else begin
         state_q <= state_d;
         widx_q  <= widx_d;
         rem_q   <= rem_d;
         id_q    <= id_d;
         out_q   <= out_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         addr_q  <= AddrWidth'(widx_d) << ByteOffset;
         blen_q  <= sub_d;
         bid_q   <= id_d;
      end
   end

   assign bus.cmd_ready_o  = (state_q == Idle);
   assign bus.breq_valid_o = valid_q;
   assign bus.breq_addr_o  = addr_q;
   assign bus.breq_blen_o  = blen_q;
   assign bus.breq_id_o    = bid_q;
   assign busy_o           = (state_q != Idle);
   assign done_o           = done_q;
   assign outstanding_o    = out_q;

   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !underflow)
      else $error("response words exceed outstanding count");
   a_no_rsp_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.rsp_valid_i && (state_q == Idle)))
      else $error("response received while idle");

endmodule

// File: tb/tb_tcdm_burst_sequencer.sv
// Directed bench for tcdm_burst_sequencer: DUT a uses default credits (8),
// DUT b runs with MaxOutstanding=4 for the credit-stall scenario.
module tb_tcdm_burst_sequencer;

   logic       clk;
   logic       rst_n;
   logic       busy_a, done_a, busy_b, done_b;
   logic [3:0] out_a;
   logic [2:0] out_b;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   tcdm_burst_sequencer_if #(.MaxBlen(4), .LenWidth(8), .AddrWidth(32), .MetaIdWidth(4)) bus_a ();
   tcdm_burst_sequencer_if #(.MaxBlen(4), .LenWidth(8), .AddrWidth(32), .MetaIdWidth(4)) bus_b ();

   tcdm_burst_sequencer #(.MaxOutstanding(8)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus_a.slave),
      .busy_o(busy_a), .done_o(done_a), .outstanding_o(out_a)
   );

   tcdm_burst_sequencer #(.MaxOutstanding(4)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus_b.slave),
      .busy_o(busy_b), .done_o(done_b), .outstanding_o(out_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_breq_a(input string tag, input logic [31:0] addr,
                               input logic [31:0] blen, input logic [31:0] id);
      check_eq({tag, "_valid"}, bus_a.breq_valid_o, 1);
      check_eq({tag, "_addr"}, bus_a.breq_addr_o, addr);
      check_eq({tag, "_blen"}, bus_a.breq_blen_o, blen);
      check_eq({tag, "_id"}, bus_a.breq_id_o, id);
   endtask

   task automatic cmd_a(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
      bus_a.cmd_addr_i  = addr;
      bus_a.cmd_len_i   = len;
      bus_a.cmd_id_i    = id;
      bus_a.cmd_valid_i = 1'b1;
   endtask

   task automatic rsp_a(input logic v, input logic [2:0] w);
      bus_a.rsp_valid_i = v;
      bus_a.rsp_words_i = w;
   endtask

   initial begin
      rst_n = 1'b0;
      bus_a.cmd_addr_i = '0; bus_a.cmd_len_i = '0; bus_a.cmd_id_i = '0; bus_a.cmd_valid_i = 1'b0;
      bus_a.breq_ready_i = 1'b0; bus_a.rsp_valid_i = 1'b0; bus_a.rsp_words_i = '0;
      bus_b.cmd_addr_i = '0; bus_b.cmd_len_i = '0; bus_b.cmd_id_i = '0; bus_b.cmd_valid_i = 1'b0;
      bus_b.breq_ready_i = 1'b0; bus_b.rsp_valid_i = 1'b0; bus_b.rsp_words_i = '0;

      // Reset state
      #2;
      check_eq("rst_cmd_ready", bus_a.cmd_ready_o, 1);
      check_eq("rst_breq_valid", bus_a.breq_valid_o, 0);
      check_eq("rst_busy", busy_a, 0);
      check_eq("rst_done", done_a, 0);
      check_eq("rst_out", out_a, 0);
      check_eq("rst_b_out", out_b, 0);
      @(negedge clk) rst_n = 1'b1;
      step();

      // 1: aligned, two full sub-bursts
      bus_a.breq_ready_i = 1'b1;
      cmd_a(32'h00, 8, 0);
      step();
      bus_a.cmd_valid_i = 1'b0;
      check_breq_a("t1_b0", 32'h00, 4, 0);
      check_eq("t1_busy", busy_a, 1);
      check_eq("t1_cmd_ready", bus_a.cmd_ready_o, 0);
      step();
      check_breq_a("t1_b1", 32'h10, 4, 4);
      check_eq("t1_out1", out_a, 4);
      rsp_a(1'b1, 4);
      step();
      check_eq("t1_drain_valid", bus_a.breq_valid_o, 0);
      check_eq("t1_out2", out_a, 4);
      check_eq("t1_done_early", done_a, 0);
      step();
      rsp_a(1'b0, 0);
      check_eq("t1_done", done_a, 1);
      check_eq("t1_idle_busy", busy_a, 0);
      check_eq("t1_out0", out_a, 0);
      step();
      check_eq("t1_done_pulse", done_a, 0);

      // 2: unaligned start, split at the 4-word group boundary
      cmd_a(32'h14, 6, 2);
      step();
      bus_a.cmd_valid_i = 1'b0;
      check_breq_a("t2_b0", 32'h14, 3, 2);
      step();
      check_breq_a("t2_b1", 32'h20, 3, 5);
      check_eq("t2_out1", out_a, 3);
      rsp_a(1'b1, 3);
      step();
      check_eq("t2_drain_valid", bus_a.breq_valid_o, 0);
      check_eq("t2_out2", out_a, 3);
      step();
      rsp_a(1'b0, 0);
      check_eq("t2_done", done_a, 1);
      step();

      // 3: zero length
      cmd_a(32'h08, 0, 1);
      step();
      bus_a.cmd_valid_i = 1'b0;
      check_eq("t3_valid", bus_a.breq_valid_o, 0);
      check_eq("t3_done", done_a, 1);
      check_eq("t3_cmd_ready", bus_a.cmd_ready_o, 1);
      check_eq("t3_busy", busy_a, 0);
      step();
      check_eq("t3_done_pulse", done_a, 0);
      check_eq("t3_valid2", bus_a.breq_valid_o, 0);

      // 4: backpressure holds the request stable
      bus_a.breq_ready_i = 1'b0;
      cmd_a(32'h00, 4, 0);
      step();
      bus_a.cmd_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_breq_a($sformatf("t4_hold%0d", i), 32'h00, 4, 0);
         step();
      end
      check_breq_a("t4_pre", 32'h00, 4, 0);
      bus_a.breq_ready_i = 1'b1;
      step();
      check_eq("t4_valid_after", bus_a.breq_valid_o, 0);
      check_eq("t4_out", out_a, 4);
      rsp_a(1'b1, 4);
      step();
      rsp_a(1'b0, 0);
      check_eq("t4_done", done_a, 1);
      step();

      // 5a: simultaneous issue and response on the default DUT
      cmd_a(32'h00, 8, 0);
      step();
      bus_a.cmd_valid_i = 1'b0;
      check_breq_a("t5a_b0", 32'h00, 4, 0);
      step();
      check_eq("t5a_out1", out_a, 4);
      rsp_a(1'b1, 2);
      step();
      check_eq("t5a_simul", out_a, 6);
      step();
      check_eq("t5a_out3", out_a, 4);
      rsp_a(1'b1, 4);
      step();
      rsp_a(1'b0, 0);
      check_eq("t5a_done", done_a, 1);
      check_eq("t5a_out0", out_a, 0);
      step();

      // 5b: credit stall with MaxOutstanding=4
      bus_b.breq_ready_i = 1'b1;
      bus_b.cmd_addr_i = 32'h00; bus_b.cmd_len_i = 8; bus_b.cmd_id_i = 0;
      bus_b.cmd_valid_i = 1'b1;
      step();
      bus_b.cmd_valid_i = 1'b0;
      check_eq("t5b_valid0", bus_b.breq_valid_o, 1);
      check_eq("t5b_addr0", bus_b.breq_addr_o, 32'h00);
      check_eq("t5b_blen0", bus_b.breq_blen_o, 4);
      step();
      check_eq("t5b_stall_valid", bus_b.breq_valid_o, 0);
      check_eq("t5b_stall_out", out_b, 4);
      step();
      check_eq("t5b_stall_valid2", bus_b.breq_valid_o, 0);
      check_eq("t5b_stall_out2", out_b, 4);
      bus_b.rsp_valid_i = 1'b1; bus_b.rsp_words_i = 4;
      step();
      bus_b.rsp_valid_i = 1'b0;
      check_eq("t5b_valid1", bus_b.breq_valid_o, 1);
      check_eq("t5b_addr1", bus_b.breq_addr_o, 32'h10);
      check_eq("t5b_blen1", bus_b.breq_blen_o, 4);
      check_eq("t5b_id1", bus_b.breq_id_o, 4);
      check_eq("t5b_out_freed", out_b, 0);
      step();
      check_eq("t5b_out2", out_b, 4);
      bus_b.rsp_valid_i = 1'b1; bus_b.rsp_words_i = 4;
      step();
      bus_b.rsp_valid_i = 1'b0;
      check_eq("t5b_done", done_b, 1);
      step();

      // 6: reset during Issue, then a fresh command
      cmd_a(32'h00, 8, 0);
      step();
      bus_a.cmd_valid_i = 1'b0;
      step();
      check_eq("t6_pre_out", out_a, 4);
      check_eq("t6_pre_valid", bus_a.breq_valid_o, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_rst_valid", bus_a.breq_valid_o, 0);
      check_eq("t6_rst_out", out_a, 0);
      check_eq("t6_rst_cmd_ready", bus_a.cmd_ready_o, 1);
      check_eq("t6_rst_busy", busy_a, 0);
      @(negedge clk) rst_n = 1'b1;
      step();
      cmd_a(32'h40, 4, 7);
      step();
      bus_a.cmd_valid_i = 1'b0;
      check_breq_a("t6_new", 32'h40, 4, 7);
      step();
      check_eq("t6_new_out", out_a, 4);
      rsp_a(1'b1, 4);
      step();
      rsp_a(1'b0, 0);
      check_eq("t6_new_done", done_a, 1);
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
